// File: rtl/systolic_tile_feeder.sv
// ---------------------------------------------------------------------------
// systolic_tile_feeder
//
// Purpose:
//   Feeds the systolic array wrapper's a/b/last inputs. One tile of up to
//   MAX_K operand beats is collected from an upstream valid/ready stream
//   into a local buffer. The tile is then replayed to the array as one
//   gap-free burst, with last_o marking the final beat. After the burst the
//   feeder stays idle for DRAIN cycles so the array can flush its pipeline.
//   Only then does it accept the next tile.
//
// Ports:
//   clk_i        clock; all logic updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   upstream beat valid
//   in_ready_o   feeder can accept a beat (LOAD state, out of reset)
//   in_a_i       a lanes of the incoming beat (lane i at [i*DATA_W +: DATA_W])
//   in_b_i       b lanes of the incoming beat
//   in_last_i    final beat of the incoming tile
//   a_o, b_o     operands to the array; zero outside the burst
//   last_o       high on the final streamed beat only
//   busy_o       high while streaming or draining
//   tile_done_o  one-cycle pulse when the drain window expires
//   overflow_o   one-cycle pulse when a tile was cut off at MAX_K beats
// ---------------------------------------------------------------------------
module systolic_tile_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int MAX_K  = 16,
    parameter int DRAIN  = 2*N+2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [N*DATA_W-1:0] in_a_i,
    input  logic [N*DATA_W-1:0] in_b_i,
    input  logic                in_last_i,
    output logic [N*DATA_W-1:0] a_o,
    output logic [N*DATA_W-1:0] b_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                tile_done_o,
    output logic                overflow_o
);

    localparam int PTR_W = $clog2(MAX_K);
    localparam int CNT_W = $clog2(DRAIN+1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_K-1);
    localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(DRAIN);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   kLast_q, kLast_d;
    logic [CNT_W-1:0]   drainCnt_q, drainCnt_d;
    logic               tileDone_q, tileDone_d;
    logic               overflow_q, overflow_d;
    logic               beatAccept;

    logic [N*DATA_W-1:0] bufA_q [MAX_K];
    logic [N*DATA_W-1:0] bufB_q [MAX_K];

    // Control registers. kLast holds K-1 so the final-beat compare uses the
    // same width as the read pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_LOAD;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            kLast_q    <= '0;
            drainCnt_q <= '0;
            tileDone_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            kLast_q    <= kLast_d;
            drainCnt_q <= drainCnt_d;
            tileDone_q <= tileDone_d;
            overflow_q <= overflow_d;
        end
    end

    // Tile buffer. It has no reset because its contents are only read after
    // they have been written within the same tile.
    always_ff @(posedge clk_i) begin
        if (beatAccept) begin
            bufA_q[wrPtr_q] <= in_a_i;
            bufB_q[wrPtr_q] <= in_b_i;
        end
    end

    // Next-state logic. A tile closes either on in_last_i or when the buffer
    // is full. In the full-buffer case the tile is truncated and flagged.
    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        kLast_d    = kLast_q;
        drainCnt_d = drainCnt_q;
        tileDone_d = 1'b0;
        overflow_d = 1'b0;
        beatAccept = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_valid_i) begin
                    beatAccept = 1'b1;
                    wrPtr_d    = wrPtr_q + PTR_W'(1);
                    if (in_last_i || (wrPtr_q == LAST_PTR)) begin
                        kLast_d    = wrPtr_q;
                        rdPtr_d    = '0;
                        overflow_d = !in_last_i;
                        state_d    = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
                if (rdPtr_q == kLast_q) begin
                    drainCnt_d = DRAIN_CNT;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drainCnt_d = drainCnt_q - CNT_W'(1);
                if (drainCnt_q == CNT_W'(1)) begin
                    tileDone_d = 1'b1;
                    wrPtr_d    = '0;
                    rdPtr_d    = '0;
                    drainCnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // The outputs decode only the state register, so an asserted reset
    // zeroes them in the same cycle. in_ready_o is also gated by rst_ni so
    // that it stays low while reset is held.
    assign in_ready_o  = (state_q == ST_LOAD) && rst_ni;
    assign busy_o      = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign a_o         = (state_q == ST_STREAM) ? bufA_q[rdPtr_q] : '0;
    assign b_o         = (state_q == ST_STREAM) ? bufB_q[rdPtr_q] : '0;
    assign last_o      = (state_q == ST_STREAM) && (rdPtr_q == kLast_q);
    assign tile_done_o = tileDone_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_tile_feeder
//
// Directed bench for systolic_tile_feeder with N=4, DATA_W=16, MAX_K=16 and
// DRAIN=10. Beat j of a tile with base value "base" carries
//   a lane i = base + j + i + 1
//   b lane i = base + j + i + 5
// so every streamed beat has a unique, hand-predictable value.
// ---------------------------------------------------------------------------
module tb_systolic_tile_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int MAX_K  = 16;
    localparam int DRAIN  = 10;

    logic                clk_i;
    logic                rst_ni;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [N*DATA_W-1:0] in_a_i;
    logic [N*DATA_W-1:0] in_b_i;
    logic                in_last_i;
    logic [N*DATA_W-1:0] a_o;
    logic [N*DATA_W-1:0] b_o;
    logic                last_o;
    logic                busy_o;
    logic                tile_done_o;
    logic                overflow_o;

    int nChecks = 0;
    int nBad    = 0;

    systolic_tile_feeder #(
        .N(N), .DATA_W(DATA_W), .MAX_K(MAX_K), .DRAIN(DRAIN)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_a_i(in_a_i),
        .in_b_i(in_b_i),
        .in_last_i(in_last_i),
        .a_o(a_o),
        .b_o(b_o),
        .last_o(last_o),
        .busy_o(busy_o),
        .tile_done_o(tile_done_o),
        .overflow_o(overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Beat pattern generators.
    function automatic logic [N*DATA_W-1:0] mkA(input int v);
        logic [N*DATA_W-1:0] r;
        for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v + i + 1);
        return r;
    endfunction

    function automatic logic [N*DATA_W-1:0] mkB(input int v);
        logic [N*DATA_W-1:0] r;
        for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v + i + 5);
        return r;
    endfunction

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer beats startIdx..k-1 of a tile. Each beat is held until it is
    // accepted. A beat that waits too long counts as a failed comparison.
    task automatic applyStimulus(input int k, input int base, input bit withLast, input int startIdx);
        for (int i = startIdx; i < k; i++) begin
            int guard;
            in_valid_i = 1'b1;
            in_a_i     = mkA(base + i);
            in_b_i     = mkB(base + i);
            in_last_i  = withLast && (i == k-1);
            guard      = 0;
            while (!in_ready_o && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) checkOutput("readyTimeout", 64'(in_ready_o), 64'd1);
            tick();
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_a_i     = '0;
        in_b_i     = '0;
    endtask

    // Check a full burst, the drain window and the tile_done pulse. The
    // first cycle of the burst is the current cycle. When holdNext is set,
    // beat 0 of the next tile (nextBase) is offered the whole time. It must
    // stay unaccepted until the tile_done cycle.
    task automatic checkTile(input int k, input int base, input bit expOvf,
                             input bit holdNext, input int nextBase);
        for (int j = 0; j < k; j++) begin
            if (holdNext) begin
                in_valid_i = 1'b1;
                in_a_i     = mkA(nextBase);
                in_b_i     = mkB(nextBase);
                in_last_i  = 1'b0;
            end
            checkOutput($sformatf("strA[%0d]", j),  64'(a_o), 64'(mkA(base + j)));
            checkOutput($sformatf("strB[%0d]", j),  64'(b_o), 64'(mkB(base + j)));
            checkOutput($sformatf("strLast[%0d]", j), 64'(last_o), 64'(j == k-1));
            checkOutput($sformatf("strBusy[%0d]", j), 64'(busy_o), 64'd1);
            checkOutput($sformatf("strRdy[%0d]", j), 64'(in_ready_o), 64'd0);
            checkOutput($sformatf("strOvf[%0d]", j), 64'(overflow_o), 64'(expOvf && j == 0));
            checkOutput($sformatf("strDone[%0d]", j), 64'(tile_done_o), 64'd0);
            tick();
        end
        for (int d = 0; d < DRAIN; d++) begin
            checkOutput($sformatf("drnA[%0d]", d),    64'(a_o), 64'd0);
            checkOutput($sformatf("drnB[%0d]", d),    64'(b_o), 64'd0);
            checkOutput($sformatf("drnLast[%0d]", d), 64'(last_o), 64'd0);
            checkOutput($sformatf("drnBusy[%0d]", d), 64'(busy_o), 64'd1);
            checkOutput($sformatf("drnRdy[%0d]", d),  64'(in_ready_o), 64'd0);
            checkOutput($sformatf("drnDone[%0d]", d), 64'(tile_done_o), 64'd0);
            checkOutput($sformatf("drnOvf[%0d]", d),  64'(overflow_o), 64'd0);
            tick();
        end
        checkOutput("doneHigh", 64'(tile_done_o), 64'd1);
        checkOutput("doneBusy", 64'(busy_o), 64'd0);
        checkOutput("doneRdy",  64'(in_ready_o), 64'd1);
        checkOutput("doneA",    64'(a_o), 64'd0);
        tick();
        checkOutput("donePulse", 64'(tile_done_o), 64'd0);
    endtask

    initial begin
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        in_a_i     = '0;
        in_b_i     = '0;
        in_last_i  = 1'b0;

        // Reset held for 5 cycles: everything is 0, including ready.
        repeat (5) tick();
        checkOutput("rstRdy",  64'(in_ready_o), 64'd0);
        checkOutput("rstA",    64'(a_o), 64'd0);
        checkOutput("rstB",    64'(b_o), 64'd0);
        checkOutput("rstLast", 64'(last_o), 64'd0);
        checkOutput("rstBusy", 64'(busy_o), 64'd0);
        checkOutput("rstDone", 64'(tile_done_o), 64'd0);
        checkOutput("rstOvf",  64'(overflow_o), 64'd0);
        #3 rst_ni = 1'b1;
        #1 checkOutput("relRdy", 64'(in_ready_o), 64'd1);
        tick();

        $display("[TB] K=3 tile");
        applyStimulus(3, 0, 1'b1, 0);
        checkTile(3, 0, 1'b0, 1'b0, 0);

        $display("[TB] K=1 tile");
        applyStimulus(1, 200, 1'b1, 0);
        checkTile(1, 200, 1'b0, 1'b0, 0);

        $display("[TB] overflow tile then back-to-back tile");
        applyStimulus(MAX_K, 50, 1'b0, 0);
        checkTile(MAX_K, 50, 1'b1, 1'b1, 100);
        // Beat 0 of the next tile was accepted at the end of the done cycle.
        applyStimulus(2, 100, 1'b1, 1);
        checkTile(2, 100, 1'b0, 1'b0, 0);

        $display("[TB] reset during stream");
        applyStimulus(3, 20, 1'b1, 0);
        checkOutput("abortA0", 64'(a_o), 64'(mkA(20)));
        tick();
        checkOutput("abortA1", 64'(a_o), 64'(mkA(21)));
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("abortA",    64'(a_o), 64'd0);
        checkOutput("abortB",    64'(b_o), 64'd0);
        checkOutput("abortLast", 64'(last_o), 64'd0);
        checkOutput("abortBusy", 64'(busy_o), 64'd0);
        tick();
        tick();
        #2 rst_ni = 1'b1;
        tick();
        checkOutput("abortRdy",  64'(in_ready_o), 64'd1);
        for (int c = 0; c < DRAIN + 4; c++) begin
            checkOutput($sformatf("abortNoDone[%0d]", c), 64'(tile_done_o), 64'd0);
            tick();
        end
        applyStimulus(2, 300, 1'b1, 0);
        checkTile(2, 300, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
